// File: rtl/cape_pkg.sv
// cape_pkg: shared offsets, reset values and sequencer state type for the cape pin sequencer
package cape_pkg;
    localparam logic [7:0] CTRL_OFS     = 8'h00;
    localparam logic [7:0] OWN_OFS      = 8'h04;
    localparam logic [7:0] PRESCALE_OFS = 8'h08;
    localparam logic [7:0] PATTERN_OFS  = 8'h0C;
    localparam logic [7:0] LENGTH_OFS   = 8'h10;
    localparam logic [7:0] STATUS_OFS   = 8'h14;
    localparam logic [2:0]  CTRL_RST    = 3'b001;
    localparam logic [31:0] OWN_RST     = 32'h0000_0020;
    localparam logic [31:0] PATTERN_RST = 32'h0000_0001;
    localparam logic [4:0]  LENGTH_RST  = 5'd1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cape_tick_gen.sv
// cape_tick_gen: step-period prescaler producing a one-cycle tick every limit+1 enabled cycles
module cape_tick_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [23:0] limit,
    output logic        tick
);
    logic [23:0] count;

    // >= keeps the period bounded when limit is lowered below the running count
    assign tick = en & (count >= limit);

    // count up while enabled, return to zero on tick or clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= tick ? '0 : count + 24'd1;
endmodule

// File: rtl/cape_pin_sequencer.sv
// cape_pin_sequencer: APB-programmed pin ownership and timed pattern sequencer for the P8 GPIO bank
module cape_pin_sequencer
    import cape_pkg::*;
#(
    parameter int          NPINS        = 28,
    parameter logic [23:0] PRESCALE_RST = 24'd4_999_999
) (
    input  logic             PCLK,
    input  logic             PRESETN,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [7:0]       paddr,
    input  logic [31:0]      pwdata,
    output logic [31:0]      prdata,
    input  logic [NPINS-1:0] mss_gpio_out,
    input  logic [NPINS-1:0] mss_gpio_oe,
    output logic [NPINS-1:0] pad_gpio_out,
    output logic [NPINS-1:0] pad_gpio_oe,
    output logic             irq
);
    logic             wr, ctrl_wr, tick, done_set, seq_bit;
    logic             enable, oneshot, irq_en, done;
    logic [NPINS-1:0] own;
    logic [23:0]      prescale;
    logic [31:0]      pattern;
    logic [4:0]       length, step, step_d;
    state_t           state, state_d;

    assign wr      = psel & penable & pwrite;
    assign ctrl_wr = wr && paddr == CTRL_OFS;

    // register file writes; unmapped offsets fall through untouched
    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) begin
            {irq_en, oneshot, enable} <= CTRL_RST;
            own      <= OWN_RST[NPINS-1:0];
            prescale <= PRESCALE_RST;
            pattern  <= PATTERN_RST;
            length   <= LENGTH_RST;
        end else if (wr) begin
            if (paddr == CTRL_OFS) {irq_en, oneshot, enable} <= pwdata[2:0];
            if (paddr == OWN_OFS) own <= pwdata[NPINS-1:0];
            if (paddr == PRESCALE_OFS) prescale <= pwdata[23:0];
            if (paddr == PATTERN_OFS) pattern <= pwdata;
            if (paddr == LENGTH_OFS) length <= pwdata[4:0];
        end

    // sticky done flag; a set in the same cycle as a W1C wins
    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) done <= 1'b0;
        else done <= done_set | (done & ~(wr && paddr == STATUS_OFS && pwdata[1]));

    cape_tick_gen u_tick (
        .clk   (PCLK),
        .rst_n (PRESETN),
        .clr   (ctrl_wr),
        .en    (state == RUN),
        .limit (prescale),
        .tick  (tick)
    );

    // sequencer state and step counter
    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) begin
            state <= RUN;
            step  <= '0;
        end else begin
            state <= state_d;
            step  <= step_d;
        end

    // next state: a CTRL write overrides any tick landing in the same cycle
    always_comb begin
        state_d  = state;
        step_d   = step;
        done_set = 1'b0;
        if (ctrl_wr) begin
            state_d = pwdata[0] ? RUN : IDLE;
            step_d  = '0;
        end else if (state == RUN && tick) begin
            if (step < length) step_d = step + 5'd1;
            else begin
                done_set = 1'b1;
                state_d  = oneshot ? DONE : RUN;
                step_d   = oneshot ? step : '0;
            end
        end
    end

    assign seq_bit      = state == RUN && pattern[step];
    assign pad_gpio_oe  = own | mss_gpio_oe;
    assign pad_gpio_out = (own & {NPINS{seq_bit}}) | (~own & mss_gpio_out);
    assign irq          = done & irq_en;

    // APB read mux, zero when deselected or unmapped
    always_comb
        prdata = !psel                 ? '0 :
                 paddr == CTRL_OFS     ? {29'd0, irq_en, oneshot, enable} :
                 paddr == OWN_OFS      ? 32'(own) :
                 paddr == PRESCALE_OFS ? {8'd0, prescale} :
                 paddr == PATTERN_OFS  ? pattern :
                 paddr == LENGTH_OFS   ? {27'd0, length} :
                 paddr == STATUS_OFS   ? {19'd0, step, 6'd0, done, state == RUN} : '0;
endmodule

// File: tb/tb_cape_pin_sequencer.sv
// tb_cape_pin_sequencer: directed scoreboard bench for the cape pin sequencer
module tb_cape_pin_sequencer;
    logic        clk = 1'b0;
    logic        PRESETN;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic [27:0] mss_gpio_out, mss_gpio_oe, pad_gpio_out, pad_gpio_oe;
    logic        irq;
    int          checks = 0;
    int          failures = 0;
    logic [10:0] q[$];

    cape_pin_sequencer dut (
        .PCLK         (clk),
        .PRESETN      (PRESETN),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .mss_gpio_out (mss_gpio_out),
        .mss_gpio_oe  (mss_gpio_oe),
        .pad_gpio_out (pad_gpio_out),
        .pad_gpio_oe  (pad_gpio_oe),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] pk(input logic irq_v, input logic p5, input logic [1:0] pins,
                                       input logic [4:0] st, input logic dn, input logic bs);
        return {irq_v, p5, pins, st, dn, bs};
    endfunction

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk);
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        @(posedge clk);
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        chk(tag, prdata, exp);
    endtask

    task automatic status_view();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h14;
    endtask

    task automatic drain(input string tag);
        int n;
        logic [10:0] e;
        n = q.size();
        status_view();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = q.pop_front();
            chk($sformatf("%s[%0d]", tag, i),
                32'(pk(irq, pad_gpio_out[5], pad_gpio_out[1:0], prdata[12:8], prdata[1], prdata[0])),
                32'(e));
        end
    endtask

    task automatic wait_step(input logic [4:0] target, input string tag);
        logic found;
        found = 1'b0;
        status_view();
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (prdata[12:8] == target) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int st;
        logic b;
        logic [3:0] p4;
        logic [7:0] pa;
        p4 = 4'b1011;
        pa = 8'hA6;
        PRESETN = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        mss_gpio_out = 28'hA5A5A5C;
        mss_gpio_oe  = 28'h0F0F0C3;
        #12;
        chk("rst_oe", 32'(pad_gpio_oe), 32'(mss_gpio_oe | 28'h20));
        chk("rst_out", 32'(pad_gpio_out), 32'(mss_gpio_out | 28'h20));
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        @(negedge clk);
        PRESETN = 1'b1;
        rd(8'h00, 32'h1, "rst_ctrl");
        rd(8'h04, 32'h20, "rst_own");
        rd(8'h08, 32'd4_999_999, "rst_prescale");
        rd(8'h0C, 32'h1, "rst_pattern");
        rd(8'h10, 32'h1, "rst_length");
        rd(8'h14, 32'h1, "rst_status");

        // default blink on bit 5 with a 4-cycle step period
        apb_write(8'h08, 32'd3);
        apb_write(8'h00, 32'h1);
        for (int i = 0; i < 16; i++) begin
            st = (i / 4) % 2;
            q.push_back(pk(1'b0, st == 0, 2'b00, 5'(st), i >= 8, 1'b1));
        end
        drain("blink");
        chk("blink_oe", 32'(pad_gpio_oe), 32'(mss_gpio_oe | 28'h20));
        chk("blink_mirror", 32'(pad_gpio_out & ~28'h20), 32'(mss_gpio_out & ~28'h20));

        // four-step pattern on pins 0-1, one step per cycle
        apb_write(8'h00, 32'h0);
        apb_write(8'h04, 32'h3);
        apb_write(8'h0C, 32'hB);
        apb_write(8'h10, 32'd3);
        apb_write(8'h08, 32'd0);
        @(negedge clk);
        chk("idle_pins", 32'(pad_gpio_out[1:0]), 32'd0);
        rd(8'h14, 32'h2, "idle_status");
        apb_write(8'h14, 32'h2);
        rd(8'h14, 32'h0, "idle_w1c");
        apb_write(8'h00, 32'h1);
        for (int i = 0; i < 8; i++) begin
            st = i % 4;
            b = p4[st];
            q.push_back(pk(1'b0, 1'b0, {b, b}, 5'(st), i >= 4, 1'b1));
        end
        drain("pat");

        // oneshot with interrupt
        apb_write(8'h00, 32'h0);
        apb_write(8'h10, 32'd2);
        apb_write(8'h08, 32'd1);
        apb_write(8'h14, 32'h2);
        apb_write(8'h00, 32'h7);
        for (int i = 0; i < 6; i++) begin
            st = i / 2;
            b = p4[st];
            q.push_back(pk(1'b0, 1'b0, {b, b}, 5'(st), 1'b0, 1'b1));
        end
        q.push_back(pk(1'b1, 1'b0, 2'b00, 5'd2, 1'b1, 1'b0));
        q.push_back(pk(1'b1, 1'b0, 2'b00, 5'd2, 1'b1, 1'b0));
        drain("oneshot");
        apb_write(8'h14, 32'h2);
        @(negedge clk);
        chk("oneshot_irq_clr", 32'(irq), 32'd0);

        // restart mid-step: first step lasts exactly PRESCALE+1 cycles
        apb_write(8'h00, 32'h0);
        apb_write(8'h0C, 32'(pa));
        apb_write(8'h10, 32'd7);
        apb_write(8'h08, 32'd5);
        apb_write(8'h00, 32'h1);
        wait_step(5'd5, "restart_wait");
        apb_write(8'h00, 32'h1);
        for (int i = 0; i < 7; i++) begin
            st = i < 6 ? 0 : 1;
            b = pa[st];
            q.push_back(pk(1'b0, 1'b0, {b, b}, 5'(st), 1'b0, 1'b1));
        end
        drain("restart");

        // shrink LENGTH below the current step: next tick wraps
        wait_step(5'd5, "shrink_wait");
        apb_write(8'h10, 32'd2);
        for (int i = 0; i < 4; i++) begin
            st = i < 3 ? 5 : 0;
            b = pa[st];
            q.push_back(pk(1'b0, 1'b0, {b, b}, 5'(st), i >= 3, 1'b1));
        end
        drain("shrink");

        // W1C landing on the wrap edge: set wins
        apb_write(8'h14, 32'h2);
        wait_step(5'd2, "setwin_wait");
        chk("setwin_pre", 32'(prdata[1]), 32'd0);
        repeat (3) @(posedge clk);
        apb_write(8'h14, 32'h2);
        status_view();
        @(negedge clk);
        chk("setwin_done", 32'({prdata[12:8], prdata[1]}), 32'({5'd0, 1'b1}));

        // unmapped offsets
        rd(8'h18, 32'h0, "unmap_rd18");
        rd(8'hFC, 32'h0, "unmap_rdfc");
        apb_write(8'h18, 32'hFFFF_FFFF);
        apb_write(8'hFC, 32'hFFFF_FFFF);
        rd(8'h00, 32'h1, "unmap_ctrl");
        rd(8'h04, 32'h3, "unmap_own");
        rd(8'h08, 32'd5, "unmap_prescale");
        rd(8'h0C, 32'(pa), "unmap_pattern");
        rd(8'h10, 32'd2, "unmap_length");

        // asynchronous reset mid-run
        apb_write(8'h00, 32'h5);
        @(negedge clk);
        chk("arst_irq_pre", 32'(irq), 32'd1);
        psel = 1'b0;
        mss_gpio_out = 28'h0F0F0D3;
        mss_gpio_oe  = 28'h00000C1;
        #2 PRESETN = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_oe", 32'(pad_gpio_oe), 32'(mss_gpio_oe | 28'h20));
        chk("arst_out", 32'(pad_gpio_out), 32'(mss_gpio_out | 28'h20));
        chk("arst_prdata", prdata, 32'd0);
        @(negedge clk);
        PRESETN = 1'b1;
        rd(8'h00, 32'h1, "arst_ctrl");
        rd(8'h04, 32'h20, "arst_own");
        psel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
